// File: rtl/ccip_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-P c0 read request channel, with response routing by ID.
// Define CCIP_ARB_STATS_EN to build the per-requester grant counters on stat_grant_cnt.
module ccip_c0_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16,
  parameter int MAX_OUTSTANDING = 64,
  parameter int ID_W            = $clog2(NUM_REQ),
  parameter int UM_W            = MDATA_W - ID_W,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      pClk,
  input  logic                      SoftReset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*UM_W-1:0]   req_mdata,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      c0TxAlmFull,
  output logic                      tx_valid,
  output logic [ADDR_W-1:0]         tx_addr,
  output logic [MDATA_W-1:0]        tx_mdata,
  input  logic                      rsp_valid,
  input  logic [MDATA_W-1:0]        rsp_mdata,
  output logic [NUM_REQ-1:0]        rsp_route,
  output logic [UM_W-1:0]           rsp_mdata_out,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      underflow_err,
  output logic [NUM_REQ*32-1:0]     stat_grant_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W:0]    NUM_REQ_V = (ID_W + 1)'(NUM_REQ);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    winner;
  logic               found;
  logic               issueEn;
  logic               transfer;
  logic [ID_W-1:0]    rspId;
  logic               rspIdOk;
  logic               rspCounted;
  logic [NUM_REQ-1:0] rspRouteNext;
  int                 searchIdx;

  // Issue gating uses the registered count, so a response at the limit frees a slot only next cycle.
  assign issueEn  = !c0TxAlmFull && (outstanding < MAX_CNT);
  assign transfer = issueEn && found;

  // Scan from the highest offset down so the last hit is the first valid requester at/after ptr.
  always_comb begin
    found     = 1'b0;
    winner    = '0;
    searchIdx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      searchIdx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[searchIdx]) begin
        found  = 1'b1;
        winner = searchIdx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = transfer && (winner == ID_W'(i));
    end
  end

  assign rspId      = rsp_mdata[MDATA_W-1:UM_W];
  assign rspIdOk    = {1'b0, rspId} < NUM_REQ_V;
  assign rspCounted = rsp_valid && (outstanding != '0);

  always_comb begin
    rspRouteNext = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rspRouteNext[i] = rsp_valid && rspIdOk && (rspId == ID_W'(i));
    end
  end

  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      ptr      <= '0;
      tx_valid <= 1'b0;
      tx_addr  <= '0;
      tx_mdata <= '0;
    end else begin
      tx_valid <= transfer;
      if (transfer) begin
        ptr      <= ID_W'((int'(winner) + 1) % NUM_REQ);
        tx_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
        tx_mdata <= {winner, req_mdata[winner*UM_W +: UM_W]};
      end
    end
  end

  // A response arriving with nothing in flight, or carrying an unknown ID, is latched as an error.
  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      outstanding   <= '0;
      underflow_err <= 1'b0;
      rsp_route     <= '0;
      rsp_mdata_out <= '0;
    end else begin
      if (transfer && !rspCounted) begin
        outstanding <= outstanding + CNT_W'(1);
      end else if (!transfer && rspCounted) begin
        outstanding <= outstanding - CNT_W'(1);
      end
      if (rsp_valid && ((outstanding == '0) || !rspIdOk)) begin
        underflow_err <= 1'b1;
      end
      rsp_route     <= rspRouteNext;
      rsp_mdata_out <= rsp_mdata[UM_W-1:0];
    end
  end

`ifdef CCIP_ARB_STATS_EN
  always_ff @(posedge pClk or posedge SoftReset) begin
    if (SoftReset) begin
      stat_grant_cnt <= '0;
    end else if (transfer) begin
      stat_grant_cnt[winner*32 +: 32] <= stat_grant_cnt[winner*32 +: 32] + 32'd1;
    end
  end
`else
  assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_ccip_c0_rd_arbiter.sv
// Directed bench for ccip_c0_rd_arbiter: a vector table for the main stream plus
// hand-written sequences for underflow, the outstanding limit and mid-stream reset.
module tb_ccip_c0_rd_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 42;
  localparam int MDATA_W   = 16;
  localparam int UM_W      = 14;
  localparam int CNT_W     = 7;
  localparam int LIM_CNT_W = 3;

  typedef struct {
    logic [3:0]  valid;
    logic        almFull;
    logic        rspV;
    logic [15:0] rspMd;
    logic [3:0]  expReady;
    logic        expTxv;
    logic [1:0]  expId;
    logic [6:0]  expOut;
    logic [3:0]  expRoute;
    logic [13:0] expMdOut;
  } vec_t;

  logic                      pClk;
  logic                      SoftReset;
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ*UM_W-1:0]   reqMdata;
  logic                      c0TxAlmFull;
  logic                      rspValid;
  logic [MDATA_W-1:0]        rspMdata;

  logic [NUM_REQ-1:0]    reqReady, limReady;
  logic                  txValid, limTxValid;
  logic [ADDR_W-1:0]     txAddr, limTxAddr;
  logic [MDATA_W-1:0]    txMdata, limTxMdata;
  logic [NUM_REQ-1:0]    rspRoute, limRspRoute;
  logic [UM_W-1:0]       rspMdataOut, limRspMdataOut;
  logic [CNT_W-1:0]      outstanding;
  logic [LIM_CNT_W-1:0]  limOutstanding;
  logic                  underflowErr, limUnderflowErr;
  logic [NUM_REQ*32-1:0] statGrantCnt, limStatGrantCnt;

  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs[$];
  int   expGrants[NUM_REQ];

  ccip_c0_rd_arbiter #(.NUM_REQ(4), .ADDR_W(42), .MDATA_W(16), .MAX_OUTSTANDING(64)) dut (
    .pClk(pClk), .SoftReset(SoftReset),
    .req_valid(reqValid), .req_addr(reqAddr), .req_mdata(reqMdata), .req_ready(reqReady),
    .c0TxAlmFull(c0TxAlmFull),
    .tx_valid(txValid), .tx_addr(txAddr), .tx_mdata(txMdata),
    .rsp_valid(rspValid), .rsp_mdata(rspMdata),
    .rsp_route(rspRoute), .rsp_mdata_out(rspMdataOut),
    .outstanding(outstanding), .underflow_err(underflowErr),
    .stat_grant_cnt(statGrantCnt)
  );

  ccip_c0_rd_arbiter #(.NUM_REQ(4), .ADDR_W(42), .MDATA_W(16), .MAX_OUTSTANDING(4)) dutLim (
    .pClk(pClk), .SoftReset(SoftReset),
    .req_valid(reqValid), .req_addr(reqAddr), .req_mdata(reqMdata), .req_ready(limReady),
    .c0TxAlmFull(c0TxAlmFull),
    .tx_valid(limTxValid), .tx_addr(limTxAddr), .tx_mdata(limTxMdata),
    .rsp_valid(rspValid), .rsp_mdata(rspMdata),
    .rsp_route(limRspRoute), .rsp_mdata_out(limRspMdataOut),
    .outstanding(limOutstanding), .underflow_err(limUnderflowErr),
    .stat_grant_cnt(limStatGrantCnt)
  );

  initial begin
    pClk = 1'b0;
    forever #5 pClk = ~pClk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic almFull,
                               input logic rspV, input logic [15:0] rspMd);
    reqValid    = valid;
    c0TxAlmFull = almFull;
    rspValid    = rspV;
    rspMdata    = rspMd;
  endtask

  task automatic addVec(input logic [3:0] valid, input logic almFull, input logic rspV,
                        input logic [15:0] rspMd, input logic [3:0] expReady, input logic expTxv,
                        input logic [1:0] expId, input logic [6:0] expOut,
                        input logic [3:0] expRoute, input logic [13:0] expMdOut);
    vec_t v;
    v.valid = valid;   v.almFull = almFull;   v.rspV = rspV;     v.rspMd = rspMd;
    v.expReady = expReady; v.expTxv = expTxv; v.expId = expId;   v.expOut = expOut;
    v.expRoute = expRoute; v.expMdOut = expMdOut;
    vecs.push_back(v);
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic doReset();
    applyStimulus(4'h0, 1'b0, 1'b0, 16'h0);
    SoftReset = 1'b1;
    repeat (2) @(posedge pClk);
    #1;
    SoftReset = 1'b0;
  endtask

  function automatic logic [15:0] expTxMdata(input logic [1:0] id);
    logic [13:0] low;
    low = 14'h100 + {12'h0, id};
    return {id, low};
  endfunction

  function automatic logic [41:0] expTxAddr(input logic [1:0] id);
    return 42'h1000 + {40'h0, id};
  endfunction

  initial begin
    SoftReset = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < NUM_REQ; i++) begin
      reqAddr[i*ADDR_W +: ADDR_W] = 42'h1000 + 42'(i);
      reqMdata[i*UM_W +: UM_W]    = 14'h100 + 14'(i);
      expGrants[i] = 0;
    end

    doReset();
    checkOutput("reset outstanding", 64'(outstanding), 64'h0);
    checkOutput("reset tx_valid", 64'(txValid), 64'h0);
    checkOutput("reset tx_mdata", 64'(txMdata), 64'h0);
    checkOutput("reset rsp_route", 64'(rspRoute), 64'h0);
    checkOutput("reset underflow_err", 64'(underflowErr), 64'h0);
`ifdef CCIP_ARB_STATS_EN
    checkOutput("reset stats", 64'(statGrantCnt[63:0]), 64'h0);
`endif

    // All requesters valid: strict rotation 0,1,2,3 twice.
    for (int n = 0; n < 8; n++) begin
      addVec(4'hF, 1'b0, 1'b0, 16'h0, 4'(1 << (n % 4)), 1'b1, 2'(n % 4), 7'(n + 1), 4'h0, 14'h0);
    end
    // Lone requester 2 gets back-to-back grants, then requester 3 has priority.
    for (int n = 0; n < 5; n++) begin
      addVec(4'h4, 1'b0, 1'b0, 16'h0, 4'h4, 1'b1, 2'd2, 7'(9 + n), 4'h0, 14'h0);
    end
    addVec(4'hF, 1'b0, 1'b0, 16'h0, 4'h8, 1'b1, 2'd3, 7'd14, 4'h0, 14'h0);
    // Almost-full blocks every grant for ten cycles.
    for (int n = 0; n < 10; n++) begin
      addVec(4'hF, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 7'd14, 4'h0, 14'h0);
    end
    addVec(4'hF, 1'b0, 1'b0, 16'h0, 4'h1, 1'b1, 2'd0, 7'd15, 4'h0, 14'h0);
    // Responses: plain, concurrent with a grant, then idle.
    addVec(4'h0, 1'b0, 1'b1, 16'h8005, 4'h0, 1'b0, 2'd0, 7'd14, 4'h4, 14'h0005);
    addVec(4'h2, 1'b0, 1'b1, 16'h4001, 4'h2, 1'b1, 2'd1, 7'd14, 4'h2, 14'h0001);
    addVec(4'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 2'd0, 7'd14, 4'h0, 14'h0);

    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].valid, vecs[n].almFull, vecs[n].rspV, vecs[n].rspMd);
      for (int i = 0; i < NUM_REQ; i++) expGrants[i] += int'(vecs[n].expReady[i]);
      #3;
      checkOutput($sformatf("v%0d req_ready", n), 64'(reqReady), 64'(vecs[n].expReady));
      @(posedge pClk);
      #1;
      checkOutput($sformatf("v%0d tx_valid", n), 64'(txValid), 64'(vecs[n].expTxv));
      if (vecs[n].expTxv) begin
        checkOutput($sformatf("v%0d tx_mdata", n), 64'(txMdata), 64'(expTxMdata(vecs[n].expId)));
        checkOutput($sformatf("v%0d tx_addr", n), 64'(txAddr), 64'(expTxAddr(vecs[n].expId)));
      end
      checkOutput($sformatf("v%0d outstanding", n), 64'(outstanding), 64'(vecs[n].expOut));
      checkOutput($sformatf("v%0d rsp_route", n), 64'(rspRoute), 64'(vecs[n].expRoute));
      checkOutput($sformatf("v%0d rsp_mdata_out", n), 64'(rspMdataOut), 64'(vecs[n].expMdOut));
    end
    checkOutput("table underflow_err", 64'(underflowErr), 64'h0);
`ifdef CCIP_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checkOutput($sformatf("stat req%0d", i), 64'(statGrantCnt[i*32 +: 32]), 64'(expGrants[i]));
    end
`endif

    // Response with nothing in flight: count stays 0, error is sticky.
    doReset();
    applyStimulus(4'h0, 1'b0, 1'b1, 16'h0003);
    @(posedge pClk);
    #1;
    checkOutput("underflow outstanding", 64'(outstanding), 64'h0);
    checkOutput("underflow set", 64'(underflowErr), 64'h1);
    applyStimulus(4'h0, 1'b0, 1'b0, 16'h0);
    for (int n = 0; n < 3; n++) begin
      @(posedge pClk);
      #1;
      checkOutput($sformatf("underflow sticky %0d", n), 64'(underflowErr), 64'h1);
    end

    // Limit of 4 on the second instance.
    doReset();
    for (int n = 0; n < 8; n++) begin
      applyStimulus(4'hF, 1'b0, 1'b0, 16'h0);
      #3;
      checkOutput($sformatf("limit ready %0d", n), 64'(limReady), (n < 4) ? 64'(1 << n) : 64'h0);
      @(posedge pClk);
      #1;
    end
    checkOutput("limit outstanding full", 64'(limOutstanding), 64'h4);
    applyStimulus(4'hF, 1'b0, 1'b1, 16'h0000);
    #3;
    checkOutput("limit ready with rsp", 64'(limReady), 64'h0);
    @(posedge pClk);
    #1;
    checkOutput("limit outstanding drop", 64'(limOutstanding), 64'h3);
    applyStimulus(4'hF, 1'b0, 1'b0, 16'h0);
    #3;
    checkOutput("limit ready resumed", 64'(limReady), 64'h1);
    @(posedge pClk);
    #1;
    checkOutput("limit outstanding refill", 64'(limOutstanding), 64'h4);
    #3;
    checkOutput("limit ready stalled", 64'(limReady), 64'h0);
    @(posedge pClk);
    #1;

    // Nine grants with two responses leave 7 in flight and the pointer at requester 1.
    doReset();
    for (int n = 0; n < 9; n++) begin
      applyStimulus(4'hF, 1'b0, (n == 4) || (n == 8), 16'h4000);
      @(posedge pClk);
      #1;
    end
    checkOutput("pre-reset outstanding", 64'(outstanding), 64'h7);
    checkOutput("pre-reset rsp_route", 64'(rspRoute), 64'h2);
    #2;
    SoftReset = 1'b1;
    #1;
    checkOutput("async reset outstanding", 64'(outstanding), 64'h0);
    checkOutput("async reset tx_valid", 64'(txValid), 64'h0);
    checkOutput("async reset rsp_route", 64'(rspRoute), 64'h0);
`ifdef CCIP_ARB_STATS_EN
    checkOutput("async reset stats", 64'(statGrantCnt), 64'h0);
`endif
    @(posedge pClk);
    #1;
    SoftReset = 1'b0;
    applyStimulus(4'hF, 1'b0, 1'b0, 16'h0);
    #3;
    checkOutput("post-reset ready", 64'(reqReady), 64'h1);
    @(posedge pClk);
    #1;
    checkOutput("post-reset tx_mdata", 64'(txMdata), 64'(expTxMdata(2'd0)));
    checkOutput("post-reset outstanding", 64'(outstanding), 64'h1);
    applyStimulus(4'h0, 1'b0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ccip_c0_rd_arbiter.md
Name: ccip_c0_rd_arbiter

Overview:
- Round-robin arbiter that shares the CCI-P c0 (read request) Tx channel among NUM_REQ requesters inside the AFU, clocked on pClk.
- Tags each issued request with the requester ID in the upper mdata bits.
- Routes c0 Rx read responses back to the originating requester.
- Enforces almost-full backpressure and a global outstanding-read credit limit.

Parameters:
NUM_REQ, 4, number of requesters (2..16); ID_W = $clog2(NUM_REQ)
ADDR_W, 42, cache-line address width
MDATA_W, 16, CCI-P mdata width; requester-owned mdata width UM_W = MDATA_W-ID_W
MAX_OUTSTANDING, 64, maximum reads in flight (1..1023); counter width CNT_W = $clog2(MAX_OUTSTANDING+1)

Ports:
pClk  in  1  400 MHz CCI-P primary clock; sole clock
SoftReset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester read request valid
req_addr  in  NUM_REQ*ADDR_W  per-requester address, requester i at slice i
req_mdata  in  NUM_REQ*UM_W  per-requester mdata
req_ready  out  NUM_REQ  grant; transfer when req_valid[i]&req_ready[i]
c0TxAlmFull  in  1  CCI-P c0 Tx almost-full
tx_valid  out  1  c0 Tx request valid
tx_addr  out  ADDR_W  c0 Tx address
tx_mdata  out  MDATA_W  {requester ID, requester mdata}
rsp_valid  in  1  c0 Rx read response valid (single-line responses only)
rsp_mdata  in  MDATA_W  response mdata
rsp_route  out  NUM_REQ  one-hot response strobe to requester
rsp_mdata_out  out  UM_W  response mdata with ID stripped
outstanding  out  CNT_W  current reads in flight
underflow_err  out  1  sticky: response received with outstanding==0
stat_grant_cnt  out  NUM_REQ*32  per-requester grant counters (optional feature)

Behaviour:
- Async reset, active-high, on SoftReset. All registered outputs reset to 0. Round-robin pointer resets to requester 0 as highest priority.
- Issue enable: en = !c0TxAlmFull && (outstanding < MAX_OUTSTANDING). All signals are sampled in the same cycle.
- req_ready is combinational: at most one bit set, and only when en is high and that requester's req_valid is high.
- Winner: the first valid requester at or after the pointer, searching upward with wrap from NUM_REQ-1 to 0.
- On a transfer, the pointer moves to winner+1, mod NUM_REQ. With no transfer, the pointer holds.
- req_ready never depends on a requester's own valid beyond the masking above. A requester may drop valid without a transfer.
- Tx stage is registered with 1-cycle latency: the cycle after a transfer, tx_valid=1, tx_addr=req_addr[w], tx_mdata={w[ID_W-1:0], req_mdata[w]}. Otherwise tx_valid=0; tx_addr and tx_mdata hold their previous values.
- outstanding update: +1 on transfer, -1 on rsp_valid, unchanged on both together or neither.
- At the limit, with outstanding==MAX_OUTSTANDING and a response in the same cycle: no grant that cycle, since the compare uses the registered count. The count drops next cycle.
- Response with outstanding==0: count stays 0 and underflow_err is set. underflow_err clears only on reset.
- Response routing, registered with 1-cycle latency: rsp_route = onehot(rsp_mdata[MDATA_W-1:UM_W]) when rsp_valid, else 0. rsp_mdata_out = rsp_mdata[UM_W-1:0].
- An ID >= NUM_REQ gives rsp_route=0 and also sets underflow_err. The outstanding count is still decremented.
- c0TxAlmFull rising stops grants in that same cycle. A Tx beat already registered still issues next cycle, as permitted by CCI-P almost-full slack.
- SoftReset asserted mid-operation clears the count, pointer, and pending Tx beat immediately. Responses to reads issued before reset are the upper level's responsibility.

Optional Feature:
- Macro CCIP_ARB_STATS_EN.
- Defined: stat_grant_cnt[i*32+:32] increments by 1 on each transfer from requester i, wraps at 2^32, resets to 0.
- Undefined: stat_grant_cnt is tied to 0 and no counter flops are synthesized.

Test Plan:
- All 4 requesters hold valid, almfull=0, MAX=64 -> grants in order 0,1,2,3,0,... one per cycle. tx_mdata[15:14] follows 0,1,2,3. outstanding reaches 8 after 8 cycles.
- Only requester 2 valid for 5 cycles -> 5 back-to-back grants to 2 and tx_valid high for 5 cycles. The pointer then gives priority to requester 3.
- Raise c0TxAlmFull for 10 cycles with all valid -> req_ready=0 for those 10 cycles. At most 1 tx_valid follows the rising edge. Grants resume the cycle after almfull drops.
- MAX_OUTSTANDING=4, no responses -> exactly 4 grants, then stall. One rsp_valid arrives -> one further grant the cycle after the count drops to 3.
- Response with mdata 0x8005 (NUM_REQ=4) -> next cycle rsp_route=0100 and rsp_mdata_out=0x0005, outstanding decrements. A response at outstanding=0 -> underflow_err=1 and stays 1.
- Assert SoftReset mid-stream with outstanding=7 -> outstanding, tx_valid, rsp_route, and the stat counters (if enabled) are all 0 asynchronously. The first grant after release goes to requester 0.
